// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst into a
// synchronous FIFO, releasing on the last beat or the burst cap.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int BURST_MAX  = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_valid_s,
  output logic [DATA_WIDTH-1:0]         o_datain,
  output logic [ID_WIDTH-1:0]           o_src_id,
  input  logic                          i_ready_s,
  input  logic                          i_almostfull,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   src_id_q, src_id_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  busy;
  logic                  beat;
  logic                  release_burst;

  // Granted requester's signals, selected by the one-hot grant register.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign busy          = (state_q == GRANT);
  assign beat          = busy & sel_valid & i_ready_s;
  assign release_burst = beat & (sel_last | (beat_cnt_q == CNT_W'(BURST_MAX - 1)));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_id_d   = src_id_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (win_found && !i_almostfull) begin
          state_d  = GRANT;
          src_id_d = win_id;
          grant_d  = NUM_REQ'(1) << win_id;
        end
      end
      GRANT: begin
        if (release_burst) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          grant_d    = '0;
          rr_ptr_d   = ID_WIDTH'((int'(src_id_q) + 1) % NUM_REQ);
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      src_id_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_id_q   <= src_id_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

  // FIFO side is a zero-latency pass-through of the granted requester.
  assign o_busy      = busy;
  assign o_grant     = grant_q;
  assign o_src_id    = src_id_q;
  assign o_valid_s   = busy & sel_valid;
  assign o_datain    = busy ? sel_data : '0;
  assign o_req_ready = grant_q & {NUM_REQ{busy & i_ready_s}};

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: packet-level requester model, per-cycle
// reference of the arbitration rules, and a per-source data-order scoreboard.
module tb_sync_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             ready_s = 1'b1;
  logic             af = 1'b0;
  logic [NR-1:0]    req_ready;
  logic             valid_s;
  logic [DW-1:0]    datain;
  logic [1:0]       src_id;
  logic [NR-1:0]    grant;
  logic             busy;

  sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_last(req_last),
    .i_req_data(req_data), .o_req_ready(req_ready), .o_valid_s(valid_s),
    .o_datain(datain), .o_src_id(src_id), .i_ready_s(ready_s),
    .i_almostfull(af), .o_grant(grant), .o_busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Requester side: beats still to send, whether the packet carries a last flag,
  // a valid gate, and a per-requester sequence number used as payload.
  int         remaining[NR];
  bit         nolast[NR];
  bit         gate[NR];
  logic [5:0] seq[NR];
  logic [5:0] exp_seq[NR];
  bit         rand_mode = 1'b0;
  bit         reload2 = 1'b0;

  // Reference: current owner (-1 when idle), pointer, beats in this grant.
  int m_owner, m_ptr, m_cnt, m_srcid, m_beats, cyc;
  int glog[$];
  int gcyc[$];
  int blog[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_log(input string tag, input int got[$], input int exp[$]);
    check_eq({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check_eq(tag, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  function automatic bit any_remaining();
    for (int k = 0; k < NR; k++) if (remaining[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k] = (remaining[k] > 0) && gate[k];
      req_last[k]  = (remaining[k] == 1) && !nolast[k];
      req_data[k*DW +: DW] = {2'(k), seq[k]};
    end
  endtask

  task automatic step();
    int exp_grant, exp_ready, exp_data, exp_vs, w, s;
    bit found;
    if (rand_mode) begin
      for (int k = 0; k < NR; k++) begin
        if (remaining[k] == 0 && $urandom_range(3) == 0) remaining[k] = 1 + $urandom_range(19);
        gate[k] = ($urandom_range(3) != 0);
      end
      ready_s = ($urandom_range(3) != 0);
      af      = ($urandom_range(5) == 0);
    end
    if (reload2)
      for (int k = 0; k < NR; k++) if (remaining[k] == 0) remaining[k] = 2;
    drive();
    @(negedge clk);
    exp_grant = 0; exp_ready = 0; exp_data = 0; exp_vs = 0;
    if (m_owner >= 0) begin
      exp_grant = 1 << m_owner;
      exp_ready = ready_s ? (1 << m_owner) : 0;
      exp_vs    = int'(req_valid[m_owner]);
      exp_data  = int'({2'(m_owner), seq[m_owner]});
    end
    check_eq("grant", grant, exp_grant);
    check_eq("busy", busy, (m_owner >= 0));
    check_eq("src_id", src_id, m_srcid);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("valid_s", valid_s, exp_vs);
    check_eq("datain", datain, exp_data);
    // Every write the FIFO takes must be the next payload of its source.
    if (busy && valid_s && ready_s) begin
      s = int'(src_id);
      check_eq("data_order", datain, {src_id, exp_seq[s]});
      exp_seq[s] = exp_seq[s] + 6'd1;
    end
    if (m_owner < 0) begin
      found = 1'b0;
      if (!af) begin
        for (int i = 0; i < NR; i++) begin
          w = (m_ptr + i) % NR;
          if (!found && req_valid[w]) begin
            found = 1'b1; m_owner = w; m_srcid = w; m_cnt = 0;
            glog.push_back(w); gcyc.push_back(cyc); blog.push_back(0);
          end
        end
      end
    end else if (req_valid[m_owner] && ready_s) begin
      w = m_owner;
      m_cnt++; m_beats++;
      s = blog.pop_back(); blog.push_back(s + 1);
      remaining[w]--; seq[w] = seq[w] + 6'd1;
      if (req_last[w] || m_cnt == BM) begin
        m_owner = -1;
        m_ptr = (w + 1) % NR;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run(input int maxc, input bit wait_idle);
    int n;
    bit done;
    n = 0;
    while (n < maxc && (any_remaining() || (wait_idle && m_owner >= 0))) begin
      step(); n++;
    end
    done = !(any_remaining() || (wait_idle && m_owner >= 0));
    check_eq("run_bound", done, 1);
  endtask

  task automatic run_beats(input int target, input int maxc);
    int n;
    n = 0;
    while (n < maxc && m_beats < target) begin step(); n++; end
    check_eq("beat_bound", m_beats, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid_s", valid_s, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_datain", datain, 0);
    check_eq("rst_src_id", src_id, 0);
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_srcid = 0; m_beats = 0; cyc = 0;
    glog.delete(); gcyc.delete(); blog.delete();
    for (int k = 0; k < NR; k++) begin remaining[k] = 0; nolast[k] = 1'b0; gate[k] = 1'b1; end
    ready_s = 1'b1; af = 1'b0; rand_mode = 1'b0; reload2 = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int e[$];
    for (int k = 0; k < NR; k++) begin seq[k] = '0; exp_seq[k] = '0; end
    #1;
    do_reset();

    // Single requester, 3-beat packet, then pointer moves past it.
    remaining[1] = 3;
    run(40, 1'b1);
    e = '{1}; check_log("single_grant", glog, e);
    e = '{3}; check_log("single_beats", blog, e);
    e = '{0}; check_log("single_latency", gcyc, e);
    glog.delete(); blog.delete(); gcyc.delete();
    remaining[0] = 1; remaining[2] = 1;
    run(40, 1'b1);
    e = '{2, 0}; check_log("rr_after_single", glog, e);

    // Fairness with all requesters continuously valid.
    #2 do_reset();
    reload2 = 1'b1;
    begin
      int n;
      n = 0;
      while (glog.size() < 5 && n < 60) begin step(); n++; end
    end
    reload2 = 1'b0;
    e = '{0, 1, 2, 3, 0}; check_log("rr_order", glog, e);
    for (int i = 0; i + 1 < gcyc.size(); i++) check_eq("rr_bubble", gcyc[i+1] - gcyc[i], 3);

    // Burst cap: 20 beats without a last flag.
    #2 do_reset();
    remaining[2] = 20; nolast[2] = 1'b1;
    run(80, 1'b0);
    e = '{2, 2, 2}; check_log("cap_grant", glog, e);
    e = '{8, 8, 4}; check_log("cap_beats", blog, e);

    // Backpressure mid-burst: the cap still lands after exactly 8 beats.
    #2 do_reset();
    remaining[0] = 10; nolast[0] = 1'b1;
    run_beats(3, 20);
    ready_s = 1'b0;
    repeat (5) step();
    check_eq("bp_frozen", m_beats, 3);
    ready_s = 1'b1;
    run(40, 1'b0);
    e = '{8, 2}; check_log("bp_beats", blog, e);

    // Almost-full gates new grants only.
    #2 do_reset();
    af = 1'b1; remaining[0] = 2;
    repeat (4) step();
    check_eq("af_no_grant", grant, 0);
    af = 1'b0;
    run_beats(1, 10);
    af = 1'b1;
    run(20, 1'b1);
    remaining[1] = 1;
    repeat (3) step();
    check_eq("af_idle_busy", busy, 0);
    af = 1'b0;
    run(20, 1'b1);
    e = '{0, 1}; check_log("af_grant", glog, e);
    e = '{2, 1}; check_log("af_beats", blog, e);

    // Reset mid-burst, then arbitration restarts at requester 0.
    #2 do_reset();
    remaining[1] = 5;
    run_beats(2, 20);
    check_eq("mid_busy", busy, 1);
    #2 do_reset();
    remaining[3] = 1; remaining[0] = 1;
    run(20, 1'b1);
    e = '{0, 3}; check_log("post_rst_order", glog, e);

    // Randomized traffic, backpressure and almost-full.
    #2 do_reset();
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
